// File: rtl/nna_pkg.sv
// nna_pkg: definitions shared by the calc serializer and the calc-side monitors.
//   CALC_ALU_W_DEF   : default operand width of the calc aggregation unit
//   calc_ser_state_t : serializer FSM state encoding (IDLE, SHIFT)
package nna_pkg;

   localparam int CALC_ALU_W_DEF = 12;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } calc_ser_state_t;

endpackage : nna_pkg

// File: rtl/calc_serializer.sv
// calc_serializer: bit-serial feeder for the calc aggregation unit.
// Accepts parallel operand words over a valid/ready handshake and shifts them
// out LSB-first, one bit per clock, with a bit-valid strobe and a frame marker.
//
// Ports:
//   clk        in  : rising-edge clock
//   rst        in  : asynchronous active-high reset
//   flush      in  : synchronous abort of the current word and frame
//   word_in    in  : operand word, taken when word_valid & word_ready
//   word_valid in  : upstream has a word
//   word_ready out : a word is accepted this cycle
//   calc_in    out : serial data bit, LSB first
//   calc_1     out : bit-valid strobe for calc_in
//   frame_last out : high on the final bit of the frame_len-th word of a frame
//   busy       out : a word is being shifted
module calc_serializer
   import nna_pkg::*;
#(
   parameter int alu_width = CALC_ALU_W_DEF,
   parameter int frame_len = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 flush,
   input  logic [alu_width-1:0] word_in,
   input  logic                 word_valid,
   output logic                 word_ready,
   output logic                 calc_in,
   output logic                 calc_1,
   output logic                 frame_last,
   output logic                 busy
);

   localparam int BC_W = (alu_width > 1) ? $clog2(alu_width) : 1;
   localparam int WC_W = (frame_len > 1) ? $clog2(frame_len) : 1;
   localparam logic [BC_W-1:0] LAST_BIT  = BC_W'(alu_width - 1);
   localparam logic [WC_W-1:0] LAST_WORD = WC_W'(frame_len - 1);

   calc_ser_state_t      r_state;
   logic [alu_width-1:0] r_sr;
   logic [BC_W-1:0]      r_bit_cnt;
   logic [WC_W-1:0]      r_word_cnt;

   logic                 w_last_bit;
   logic                 w_last_word;
   logic                 w_shifting;
   logic [WC_W-1:0]      w_word_cnt_nxt;

   assign w_shifting     = (r_state == SHIFT);
   assign w_last_bit     = (r_bit_cnt == LAST_BIT);
   assign w_last_word    = (r_word_cnt == LAST_WORD);
   assign w_word_cnt_nxt = w_last_word ? {WC_W{1'b0}} : (r_word_cnt + WC_W'(1));

   // A new word can enter while idle or on the last bit of the current word,
   // which is what gives back-to-back words zero bubble cycles.
   assign word_ready = !flush && (!w_shifting || w_last_bit);

   // Outputs decode registered state only; no path from any input.
   assign calc_in    = w_shifting & r_sr[0];
   assign calc_1     = w_shifting;
   assign frame_last = w_shifting & w_last_bit & w_last_word;
   assign busy       = w_shifting;

   // FSM, shift register, bit counter and word counter.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= IDLE;
         r_sr       <= {alu_width{1'b0}};
         r_bit_cnt  <= {BC_W{1'b0}};
         r_word_cnt <= {WC_W{1'b0}};
      end else if (flush) begin
         // Flush discards the partial word and restarts the frame count.
         r_state    <= IDLE;
         r_sr       <= {alu_width{1'b0}};
         r_bit_cnt  <= {BC_W{1'b0}};
         r_word_cnt <= {WC_W{1'b0}};
      end else begin
         case (r_state)
            IDLE: begin
               if (word_valid) begin
                  r_sr      <= word_in;
                  r_bit_cnt <= {BC_W{1'b0}};
                  r_state   <= SHIFT;
               end else begin
                  r_state   <= IDLE;
               end
            end
            SHIFT: begin
               if (w_last_bit) begin
                  r_word_cnt <= w_word_cnt_nxt;
                  r_bit_cnt  <= {BC_W{1'b0}};
                  if (word_valid) begin
                     r_sr    <= word_in;
                     r_state <= SHIFT;
                  end else begin
                     r_sr    <= {alu_width{1'b0}};
                     r_state <= IDLE;
                  end
               end else begin
                  r_sr      <= r_sr >> 1;
                  r_bit_cnt <= r_bit_cnt + BC_W'(1);
               end
            end
            default: begin
               r_state    <= IDLE;
               r_sr       <= {alu_width{1'b0}};
               r_bit_cnt  <= {BC_W{1'b0}};
               r_word_cnt <= {WC_W{1'b0}};
            end
         endcase
      end
   end

endmodule : calc_serializer
